// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx: memory-mapped UART transmitter with a small TX FIFO and programmable divisor.
//   clock    - system clock, all state on rising edge
//   reset    - synchronous active-high reset
//   IORead   - CPU I/O read strobe
//   IOWrite  - CPU I/O write strobe
//   io_addr  - offset in I/O page: 0x000 TXDATA (wo), 0x004 STATUS, 0x008 DIV
//   io_wdata - store data
//   io_rdata - load data, combinational, 0 when IORead=0
//   uart_tx  - registered serial line, idle high
module mmio_uart_tx #(
   parameter logic [15:0] BAUD_DIV   = 16'd10416,
   parameter int          FIFO_DEPTH = 4
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        IORead,
   input  logic        IOWrite,
   input  logic [9:0]  io_addr,
   input  logic [31:0] io_wdata,
   output logic [31:0] io_rdata,
   output logic        uart_tx
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   state_t          state_q, state_d;
   logic [7:0]      mem_q [FIFO_DEPTH];
   logic [AW-1:0]   wptr_q, wptr_d, rptr_q, rptr_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            ovf_q, ovf_d;
   logic [15:0]     div_q, div_d, cdiv_q, cdiv_d, baud_q, baud_d;
   logic [2:0]      bit_q, bit_d;
   logic [7:0]      sh_q, sh_d;
   logic            tx_q, tx_d;

   logic sel_tx, sel_st, sel_dv, full, empty, push, pop, bit_end;
   logic unused_hi;

   assign sel_tx    = io_addr == 10'h000;
   assign sel_st    = io_addr == 10'h004;
   assign sel_dv    = io_addr == 10'h008;
   // full is pre-edge occupancy, so a write while full is dropped even if a pop happens this edge
   assign full      = cnt_q == CW'(FIFO_DEPTH);
   assign empty     = cnt_q == '0;
   assign push      = IOWrite & sel_tx & ~full;
   assign pop       = (state_q == IDLE) & ~empty;
   assign bit_end   = baud_q == cdiv_q - 16'd1;
   assign unused_hi = ^io_wdata[31:16];
   assign uart_tx   = tx_q;

   assign io_rdata = !IORead ? 32'b0 :
                     sel_st  ? {28'b0, ovf_q, full, empty, state_q != IDLE} :
                     sel_dv  ? {16'b0, div_q} : 32'b0;

   always_comb begin
      state_d = state_q;
      sh_d    = sh_q;
      cdiv_d  = cdiv_q;
      bit_d   = bit_q;
      tx_d    = tx_q;
      ovf_d   = (IOWrite & sel_tx & full) | (ovf_q & ~(IOWrite & sel_st & io_wdata[3]));
      div_d   = !(IOWrite & sel_dv) ? div_q : (io_wdata[15:0] < 16'd2) ? 16'd2 : io_wdata[15:0];
      wptr_d  = push ? wptr_q + AW'(1) : wptr_q;
      rptr_d  = pop ? rptr_q + AW'(1) : rptr_q;
      cnt_d   = cnt_q + CW'(push) - CW'(pop);
      baud_d  = (state_q == IDLE || bit_end) ? 16'd0 : baud_q + 16'd1;
      case (state_q)
         IDLE: begin
            tx_d  = 1'b1;
            bit_d = 3'd0;
            if (pop) begin
               state_d = START;
               sh_d    = mem_q[rptr_q];
               cdiv_d  = div_q;
               tx_d    = 1'b0;
            end
         end
         START: begin
            if (bit_end) begin
               state_d = DATA;
               tx_d    = sh_q[0];
            end
         end
         DATA: begin
            if (bit_end) begin
               if (bit_q == 3'd7) begin
                  state_d = STOP;
                  tx_d    = 1'b1;
               end else begin
                  bit_d = bit_q + 3'd1;
                  sh_d  = sh_q >> 1;
                  tx_d  = sh_q[1];
               end
            end
         end
         STOP: begin
            if (bit_end) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= IDLE;
         wptr_q  <= '0;
         rptr_q  <= '0;
         cnt_q   <= '0;
         ovf_q   <= 1'b0;
         div_q   <= BAUD_DIV;
         cdiv_q  <= BAUD_DIV;
         baud_q  <= 16'd0;
         bit_q   <= 3'd0;
         sh_q    <= 8'd0;
         tx_q    <= 1'b1;
      end else begin
         state_q <= state_d;
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         cnt_q   <= cnt_d;
         ovf_q   <= ovf_d;
         div_q   <= div_d;
         cdiv_q  <= cdiv_d;
         baud_q  <= baud_d;
         bit_q   <= bit_d;
         sh_q    <= sh_d;
         tx_q    <= tx_d;
      end
   end

   always_ff @(posedge clock) begin
      if (push) mem_q[wptr_q] <= io_wdata[7:0];
   end
endmodule

// File: doc/mmio_uart_tx.md
MMIO_UART_TX -- requirements
Module: mmio_uart_tx

Interface
REQ-001 SHALL have parameter BAUD_DIV, default 16'd10416, reset value of the divisor register (clocks per bit).
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, number of TX FIFO entries (power of two).
REQ-003 SHALL have port clock  input  1  single system clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port IORead  input  1  CPU I/O read strobe from instruction decode.
REQ-006 SHALL have port IOWrite  input  1  CPU I/O write strobe from instruction decode.
REQ-007 SHALL have port io_addr  input  10  ALU result bits [9:0], the offset within the I/O page 0xFFFFFC00.
REQ-008 SHALL have port io_wdata  input  32  store data.
REQ-009 SHALL have port io_rdata  output  32  load data, combinational.
REQ-010 SHALL have port uart_tx  output  1  serial line, idle high.

Function
REQ-011 SHALL decode io_addr 0x000 as TXDATA (write-only), 0x004 as STATUS (read/write), and 0x008 as DIV (read/write); all other offsets read 0 and ignore writes.
REQ-012 SHALL, on IOWrite to TXDATA, push io_wdata[7:0] into the FIFO if it is not full; a write while full is dropped and sets sticky overflow.
REQ-013 SHALL evaluate full using pre-edge state: a write while full is dropped even if a pop occurs on the same edge.
REQ-014 SHALL read STATUS as {28'b0, overflow, full, empty, busy}, where busy = FSM not in IDLE.
REQ-015 SHALL clear overflow on an IOWrite to STATUS with io_wdata[3]=1; other STATUS bits are read-only.
REQ-016 SHALL read DIV as {16'b0, div}; an IOWrite to DIV loads io_wdata[15:0], clamping values below 2 to 2.
REQ-017 SHALL drive io_rdata to 0 whenever IORead=0.
REQ-018 SHALL implement the FSM states IDLE, START, DATA, STOP.
REQ-019 SHALL, in IDLE, pop the FIFO when it is non-empty, latch the byte and the current div, and enter START; a div change takes effect only at the next pop.
REQ-020 SHALL hold uart_tx=0 in START for div clocks, then enter DATA.
REQ-021 SHALL in DATA shift out 8 bits LSB first, each held for div clocks, then enter STOP.
REQ-022 SHALL hold uart_tx=1 in STOP for div clocks, then enter IDLE.
REQ-023 SHALL register uart_tx and set it to 1 in IDLE.
REQ-024 SHALL give a frame length of exactly 10*div clocks.
REQ-025 SHALL make the start bit appear at most 2 clocks after the write edge when idle: the write edge fills the FIFO, the next edge pops and drives uart_tx low.
REQ-026 SHALL leave at most 1 idle-high clock between back-to-back frames (the IDLE pop cycle).
REQ-027 SHALL wrap the FIFO pointers modulo FIFO_DEPTH and use an occupancy count of width log2(FIFO_DEPTH)+1.
REQ-028 SHALL handle an IOWrite to TXDATA while empty and IDLE by storing the byte on that edge and popping it on the next edge; there is no bypass.
REQ-029 SHALL treat a simultaneous IORead and IOWrite to the same register as independent: the read returns pre-edge state.

Reset
REQ-030 SHALL, on reset at any time including mid-frame, take effect on the next edge: state=IDLE, uart_tx=1, FIFO empty (pointers and count 0), overflow=0, div=BAUD_DIV, bit counter and baud counter 0.
REQ-031 SHALL keep io_rdata combinational after reset, so a STATUS read returns 32'h2.

Verification
REQ-032 SHALL be verified for a single byte: BAUD_DIV=4, write 0x55 to TXDATA -> uart_tx low 2 clocks after the write, then bits 1,0,1,0,1,0,1,0 at 4 clocks each, stop high; 40-clock frame; busy=1 throughout.
REQ-033 SHALL be verified for overflow: with div=100, write 6 bytes back-to-back -> first popped, 4 queued, 6th dropped; STATUS=0xD (overflow, full, busy); writing STATUS with 0x8 clears it to 0x5.
REQ-034 SHALL be verified for a divisor change: write DIV=0x0001 -> DIV reads 2; a change mid-frame leaves the current frame at the old rate and the next frame uses 2 clocks per bit.
REQ-035 SHALL be verified for reset mid-frame: assert reset during DATA bit 3 -> uart_tx=1 next clock, STATUS=0x2, DIV=BAUD_DIV; no residual frame afterwards.
REQ-036 SHALL be verified for back-to-back frames: queue 0xA5 and 0x3C -> frames are contiguous with exactly 1 high clock between stop and start; empty=1 after the second pop.
REQ-037 SHALL be verified for unmapped access: IORead at 0x00C returns 0; IOWrite at 0x010 changes no state; IORead=0 gives io_rdata=0.
